// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the PC / branch-redirect stage.
// Holds the FSM state enum, default widths and stack-pointer sizing.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } pc_state_e;

  localparam int PC_ADDR_W      = 10;
  localparam int PC_RESET_PC    = 0;
  localparam int PC_STACK_DEPTH = 4;
  localparam int PC_SP_W        = $clog2(PC_STACK_DEPTH) + 1;

  // Pointer counts 0..depth inclusive, hence one extra bit.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pc_branch_unit_ret_stack.sv
// ret_stack: LIFO of return addresses (push/pop/full/empty, sync reset).
// Ports: clk, rst, push, pop, din -> dout (top of stack), full, empty.
module ret_stack
  import pc_pkg::*;
#(
  parameter int W     = PC_ADDR_W,
  parameter int DEPTH = PC_STACK_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int SPW = sp_width(DEPTH);
  localparam int IW  = SPW - 1;

  logic [W-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_m1;
  logic           do_push;
  logic           do_pop;

  assign sp_m1   = sp - SPW'(1);
  assign full    = (sp == SPW'(DEPTH));
  assign empty   = (sp == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[sp_m1[IW-1:0]];

  // Only the pointer is reset; contents survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SPW'(1);
    end else if (do_pop) begin
      sp <= sp_m1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[sp[IW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC sequencer with branch redirect, flush bubble and
// optional return stack (`PC_CALL_STACK_EN). Ports: clk, rst, stall,
// br_cond, br_uncond, jmp, call, ret, br_target -> pc, pc_valid,
// flush, taken, err_ovf, err_unf.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W      = PC_ADDR_W,
  parameter int RESET_PC    = PC_RESET_PC,
  parameter int STACK_DEPTH = PC_STACK_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_cond,
  input  logic              br_uncond,
  input  logic              jmp,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              taken,
  output logic              err_ovf,
  output logic              err_unf
);

  pc_state_e         state;
  pc_state_e         state_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt;
  logic              redirect;

  assign pc_inc = pc + ADDR_W'(1);

`ifdef PC_CALL_STACK_EN
  logic [ADDR_W-1:0] ra;
  logic              full;
  logic              empty;
  logic              adv;
  logic              push;
  logic              pop;

  assign adv  = (state == RUN) && !stall;
  // ret outranks call; an empty-stack ret degrades to sequential.
  assign push = adv && !ret && call && !full;
  assign pop  = adv && ret && !empty;
  assign redirect = ret ? !empty
                  : (call | br_uncond | (br_cond & jmp));
  assign tgt = (ret && !empty) ? ra : br_target;

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (ra),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (adv) begin
      if (!ret && call && full) err_ovf <= 1'b1;
      if (ret && empty)         err_unf <= 1'b1;
    end
  end
`else
  logic        unused_ret;
  logic [31:0] unused_depth;

  assign unused_ret   = ret;
  assign unused_depth = STACK_DEPTH;
  assign redirect = call | br_uncond | (br_cond & jmp);
  assign tgt      = br_target;
  assign err_ovf  = 1'b0;
  assign err_unf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else if (!stall) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = redirect ? BUBBLE : RUN;
      BUBBLE:  state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    pc_valid = 1'b0;
    flush    = 1'b0;
    unique case (state)
      RUN:     pc_valid = 1'b1;
      BUBBLE: begin
        pc_valid = 1'b1;
        flush    = 1'b1;
      end
      default: pc_valid = 1'b0;
    endcase
  end

  // BOOT holds the PC; BUBBLE ignores controls of the killed insn.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= ADDR_W'(RESET_PC);
      taken <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        RUN: begin
          pc    <= redirect ? tgt : pc_inc;
          taken <= redirect;
        end
        BUBBLE: begin
          pc    <= pc_inc;
          taken <= 1'b0;
        end
        default: taken <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb_pc_branch_unit: scoreboard bench for pc_branch_unit.
// Expected outputs are queued per driven cycle and compared after the edge.
module tb_pc_branch_unit;

  typedef enum logic [3:0] {
    K_SEQ, K_RST, K_COND_T, K_COND_NT, K_UNC,
    K_CALL, K_RET, K_STALL, K_MIX, K_RSTSTALL
  } kind_e;

  typedef struct packed {
    kind_e      k;
    logic [9:0] t;
  } stim_t;

  // fl = {pc_valid, flush, taken, err_ovf, err_unf}
  typedef struct packed {
    logic [9:0] p;
    logic [4:0] fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, stall, br_cond, br_uncond, jmp, call, ret;
  logic [9:0] br_target;
  logic [9:0] pc;
  logic       pc_valid, flush, taken, err_ovf, err_unf;

  int n_vec = 0;
  int n_err = 0;

  stim_t plan_s[$];
  exp_t  plan_e[$];
  exp_t  sb[$];

  always #5 clk = ~clk;

  pc_branch_unit #(
    .ADDR_W      (10),
    .RESET_PC    (0),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_cond   (br_cond),
    .br_uncond (br_uncond),
    .jmp       (jmp),
    .call      (call),
    .ret       (ret),
    .br_target (br_target),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .flush     (flush),
    .taken     (taken),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf)
  );

  function automatic exp_t obs();
    exp_t o;
    o.p  = pc;
    o.fl = {pc_valid, flush, taken, err_ovf, err_unf};
    return o;
  endfunction

  task automatic add(input kind_e k, input logic [9:0] t,
                     input logic [9:0] p, input logic [4:0] fl);
    stim_t s;
    exp_t  e;
    s.k = k;
    s.t = t;
    e.p = p;
    e.fl = fl;
    plan_s.push_back(s);
    plan_e.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    rst = 1'b0; stall = 1'b0; br_cond = 1'b0;
    br_uncond = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    br_target = s.t;
    case (s.k)
      K_RST:      rst = 1'b1;
      K_COND_T:   begin br_cond = 1'b1; jmp = 1'b1; end
      K_COND_NT:  br_cond = 1'b1;
      K_UNC:      br_uncond = 1'b1;
      K_CALL:     call = 1'b1;
      K_RET:      ret = 1'b1;
      K_STALL:    stall = 1'b1;
      K_MIX:      begin br_cond = 1'b1; br_uncond = 1'b1; end
      K_RSTSTALL: begin rst = 1'b1; stall = 1'b1; br_uncond = 1'b1; end
      default:    ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e, o;
    add(K_RST, 10'h0,   10'h000, 5'b00000);
    add(K_RST, 10'h0,   10'h000, 5'b00000);
    add(K_RST, 10'h0,   10'h000, 5'b00000);
    add(K_SEQ, 10'h0,   10'h000, 5'b10000);
    add(K_SEQ, 10'h0,   10'h001, 5'b10000);
    add(K_SEQ, 10'h0,   10'h002, 5'b10000);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

  task automatic test_cond_branch();
    exp_t e, o;
    add(K_SEQ,     10'h000, 10'h003, 5'b10000);
    add(K_SEQ,     10'h000, 10'h004, 5'b10000);
    add(K_SEQ,     10'h000, 10'h005, 5'b10000);
    add(K_COND_T,  10'h040, 10'h040, 5'b11100);
    add(K_SEQ,     10'h000, 10'h041, 5'b10000);
    add(K_UNC,     10'h004, 10'h004, 5'b11100);
    add(K_SEQ,     10'h000, 10'h005, 5'b10000);
    add(K_COND_NT, 10'h040, 10'h006, 5'b10000);
    add(K_SEQ,     10'h000, 10'h007, 5'b10000);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL cond[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

  task automatic test_bubble_ignore();
    exp_t e, o;
    add(K_UNC, 10'h040, 10'h040, 5'b11100);
    add(K_UNC, 10'h010, 10'h041, 5'b10000);
    add(K_SEQ, 10'h000, 10'h042, 5'b10000);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL bubble[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    add(K_UNC, 10'h3FE, 10'h3FE, 5'b11100);
    add(K_SEQ, 10'h000, 10'h3FF, 5'b10000);
    add(K_SEQ, 10'h000, 10'h000, 5'b10000);
    add(K_SEQ, 10'h000, 10'h001, 5'b10000);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

  task automatic test_stall_bubble();
    exp_t e, o;
    add(K_UNC,   10'h080, 10'h080, 5'b11100);
    add(K_STALL, 10'h000, 10'h080, 5'b11100);
    add(K_STALL, 10'h000, 10'h080, 5'b11100);
    add(K_SEQ,   10'h000, 10'h081, 5'b10000);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e, o;
    add(K_MIX,  10'h123, 10'h123, 5'b11100);
    add(K_SEQ,  10'h000, 10'h124, 5'b10000);
    add(K_CALL, 10'h200, 10'h200, 5'b11100);
    add(K_SEQ,  10'h000, 10'h201, 5'b10000);
`ifdef PC_CALL_STACK_EN
    add(K_RET,  10'h300, 10'h125, 5'b11100);
    add(K_SEQ,  10'h000, 10'h126, 5'b10000);
`else
    add(K_RET,  10'h300, 10'h202, 5'b10000);
    add(K_SEQ,  10'h000, 10'h203, 5'b10000);
`endif
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL prio[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

  task automatic test_rst_mid_bubble();
    exp_t e, o;
    add(K_UNC,      10'h055, 10'h055, 5'b11100);
    add(K_RSTSTALL, 10'h066, 10'h000, 5'b00000);
    add(K_SEQ,      10'h000, 10'h000, 5'b10000);
    add(K_SEQ,      10'h000, 10'h001, 5'b10000);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL rstbub[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask

`ifdef PC_CALL_STACK_EN
  task automatic test_stack();
    exp_t e, o;
    add(K_RST,  10'h000, 10'h000, 5'b00000);
    add(K_SEQ,  10'h000, 10'h000, 5'b10000);
    add(K_SEQ,  10'h000, 10'h001, 5'b10000);
    add(K_CALL, 10'h010, 10'h010, 5'b11100);
    add(K_SEQ,  10'h000, 10'h011, 5'b10000);
    add(K_CALL, 10'h020, 10'h020, 5'b11100);
    add(K_SEQ,  10'h000, 10'h021, 5'b10000);
    add(K_CALL, 10'h030, 10'h030, 5'b11100);
    add(K_SEQ,  10'h000, 10'h031, 5'b10000);
    add(K_CALL, 10'h040, 10'h040, 5'b11100);
    add(K_SEQ,  10'h000, 10'h041, 5'b10000);
    add(K_CALL, 10'h050, 10'h050, 5'b11110);
    add(K_SEQ,  10'h000, 10'h051, 5'b10010);
    add(K_RET,  10'h000, 10'h032, 5'b11110);
    add(K_SEQ,  10'h000, 10'h033, 5'b10010);
    add(K_RET,  10'h000, 10'h022, 5'b11110);
    add(K_SEQ,  10'h000, 10'h023, 5'b10010);
    add(K_RET,  10'h000, 10'h012, 5'b11110);
    add(K_SEQ,  10'h000, 10'h013, 5'b10010);
    add(K_RET,  10'h000, 10'h002, 5'b11110);
    add(K_SEQ,  10'h000, 10'h003, 5'b10010);
    add(K_RET,  10'h000, 10'h004, 5'b10011);
    add(K_SEQ,  10'h000, 10'h005, 5'b10011);
    for (int i = 0; plan_s.size() > 0; i++) begin
      apply(plan_s.pop_front());
      sb.push_back(plan_e.pop_front());
      tick();
      e = sb.pop_front(); o = obs(); n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stack[%0d]: got pc=%h fl=%b want pc=%h fl=%b",
                 i, o.p, o.fl, e.p, e.fl);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; br_cond = 1'b0; br_uncond = 1'b0;
    jmp = 1'b0; call = 1'b0; ret = 1'b0; br_target = '0;
    test_reset();
    test_cond_branch();
    test_bubble_ignore();
    test_wrap();
    test_stall_bubble();
    test_priority();
    test_rst_mid_bubble();
`ifdef PC_CALL_STACK_EN
    test_stack();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Program-counter and branch-redirect stage that sits directly downstream of the flag-condition multiplexer. It samples the mux's `jmp` decision together with the decoded branch controls, and either advances the PC sequentially or redirects it to a branch target. After every redirect it raises a one-cycle `flush` so decode can kill the wrong-path instruction. An optional return-address stack supports call/return.

## Interface
- `ADDR_W`, 10, PC/target width in bits
- `RESET_PC`, 0, PC value loaded by reset
- `STACK_DEPTH`, 4, return-stack entries (power of two, ≥2); used only with the stack feature
- `clk`  in  1  rising-edge clock, single clock domain
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold all state this cycle
- `br_cond`  in  1  current instruction is a conditional branch; taken iff `jmp`=1
- `br_uncond`  in  1  current instruction is an unconditional jump
- `jmp`  in  1  condition result from the flag mux, valid in the same cycle as `br_cond`
- `call`  in  1  call: push PC+1, jump to `br_target`
- `ret`  in  1  return: pop the stack into the PC
- `br_target`  in  ADDR_W  absolute target address
- `pc`  out  ADDR_W  current fetch address
- `pc_valid`  out  1  `pc` is a valid fetch address
- `flush`  out  1  kill the instruction currently in decode
- `taken`  out  1  registered: the last accepted instruction redirected the PC
- `err_ovf`  out  1  sticky: call issued with the stack full
- `err_unf`  out  1  sticky: ret issued with the stack empty

## Operation
- States: BOOT, RUN, BUBBLE.
- BOOT: entered on `rst`. `pc`=RESET_PC, `pc_valid`=0. Leaves for RUN on the next non-stalled cycle; PC is not incremented on this transition.
- RUN: `pc_valid`=1. Decision priority: `ret` > `call` > `br_uncond` > (`br_cond` & `jmp`) > sequential.
  - Redirect: PC ← target (or the popped address for `ret`); `taken` ← 1; next state BUBBLE.
  - Otherwise: PC ← PC+1; `taken` ← 0.
- BUBBLE: `flush`=1, `pc_valid`=1. All branch/call/ret inputs are ignored, since they belong to the killed instruction. PC ← PC+1; `taken` ← 0; next state RUN.
- Arithmetic: PC+1 is modulo 2^ADDR_W, so all-ones wraps to 0 with no error. Return addresses are PC+1 with the same wrap.
- `stall`=1: PC, state, `taken`, the stack and the error flags all hold. Outputs keep their current values, so `flush` stays high in a stalled BUBBLE.
- Several control inputs asserted together: resolved by the priority above; only one action occurs.
- `rst` overrides `stall` and everything else.

## Timing
- Reset values: `pc`=RESET_PC, `pc_valid`=0, `flush`=0, `taken`=0, `err_ovf`=0, `err_unf`=0, stack pointer=0 (empty).
- `pc_valid` and `flush` decode from the state register only; `jmp` has no combinational path to any output.
- Redirect latency: controls sampled on edge k → `pc`=target in cycle k+1 with `flush`=1 → `pc`=target+1 in cycle k+2 with `flush`=0. This assumes no stalls.
- `rst` asserted mid-BUBBLE or mid-stack-operation: the next cycle is BOOT with all reset values. Stack contents are not cleared, only the pointer.

## Configuration
- `PC_CALL_STACK_EN` defined: return stack of STACK_DEPTH × ADDR_W.
  - Call with the stack full: sets `err_ovf`; no push; the jump is still taken.
  - Ret with the stack empty: sets `err_unf`; treated as sequential (PC+1, no redirect, no flush).
  - Call and ret never occur together; ret wins by priority.
- `PC_CALL_STACK_EN` undefined: no stack is instantiated. `call` behaves as `br_uncond`. `ret` is ignored (sequential). `err_ovf` and `err_unf` are tied to 0.

## Structure
- Package `pc_pkg` holds:
  - the state enum (BOOT/RUN/BUBBLE);
  - the default ADDR_W and RESET_PC constants;
  - the localparam for the stack-pointer width, $clog2(STACK_DEPTH)+1.
- One sub-module: `ret_stack`. It is a LIFO with push/pop/full/empty and a synchronous-reset pointer, instantiated only under `PC_CALL_STACK_EN`.

## Test plan
- Reset and boot: hold `rst` for 3 cycles, then release.
  - Required: `pc`=0 and `pc_valid`=0 for one cycle after release, then `pc`=0,1,2 with `pc_valid`=1.
- Conditional branch: at `pc`=5, drive `br_cond`=1, `jmp`=1, `br_target`=0x40.
  - Required: next cycle `pc`=0x40 with `flush`=1 and `taken`=1, then `pc`=0x41 with `flush`=0.
  - Same stimulus with `jmp`=0 → `pc`=6, no flush.
- Inputs ignored in BUBBLE: drive `br_uncond`=1 with target 0x10 during the BUBBLE cycle after a jump to 0x40.
  - Required: `pc`=0x41; no second redirect.
- Wrap-around: with ADDR_W=10 and `pc`=0x3FF, run sequentially.
  - Required: `pc`=0x000 next cycle, no error flags.
- Stall in BUBBLE: take a jump, then hold `stall` for 2 cycles.
  - Required: `pc`=target and `flush`=1 for all 3 cycles, then advance to target+1.
- Stack (`PC_CALL_STACK_EN`, STACK_DEPTH=4):
  - Five calls from pc=1,0x11,0x21,0x31,0x41 → `err_ovf`=1 on the fifth call.
  - Four rets then return to 0x32, 0x22, 0x12, 0x02.
  - A fifth ret sets `err_unf`=1 and advances PC by 1.
